// File: rtl/mod_exp_ctrl_pkg.sv
// Shared constants and FSM state type for the modular-exponentiation controller.
// Field is the BLS12-381 scalar modulus with Montgomery radix R = 2^255.
package mod_exp_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 255;

  localparam logic [DATA_WIDTH-1:0] MODULUS =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

  // R mod MODULUS, i.e. the value 1 in Montgomery form
  localparam logic [DATA_WIDTH-1:0] MONT_ONE =
    255'h0c1258acd66282b7ccc627f7f65e27faac425bfd0001a40100000000ffffffff;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_SQR,
    WAIT_SQR,
    ISSUE_MUL,
    WAIT_MUL,
    DONE
  } state_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier over valid/ready; one multiplier transaction in flight at a time.
module mod_exp_ctrl #(
  parameter int unsigned               DATA_WIDTH = mod_exp_ctrl_pkg::DATA_WIDTH,
  parameter int unsigned               EXP_WIDTH  = 255,
  parameter logic [DATA_WIDTH-1:0]     MONT_ONE   = mod_exp_ctrl_pkg::MONT_ONE
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [DATA_WIDTH-1:0] base_i,
  input  logic [EXP_WIDTH-1:0]  exp_i,

  output logic                  mul_valid_o,
  input  logic                  mul_ready_i,
  output logic [DATA_WIDTH-1:0] mul_op1_o,
  output logic [DATA_WIDTH-1:0] mul_op2_o,

  input  logic                  mul_res_valid_i,
  output logic                  mul_res_ready_o,
  input  logic [DATA_WIDTH-1:0] mul_res_i,

  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  import mod_exp_ctrl_pkg::*;

  localparam int unsigned       CNT_W    = $clog2(EXP_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   base_q;
  logic [DATA_WIDTH-1:0]   op2_q;
  logic [EXP_WIDTH-1:0]    exp_q;
  logic [CNT_W-1:0]        cnt;
  logic                    bit_set;

  // exp_q shifts left so its MSB is always the bit being processed
  assign bit_set   = exp_q[EXP_WIDTH-1];
  assign mul_op1_o = acc;
  assign mul_op2_o = op2_q;
  assign res_o     = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_ready_o      <= 1'b1;
      mul_valid_o     <= 1'b0;
      mul_res_ready_o <= 1'b0;
      res_valid_o     <= 1'b0;
      acc             <= MONT_ONE;
      base_q          <= '0;
      op2_q           <= '0;
      exp_q           <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid_i) begin
            base_q      <= base_i;
            exp_q       <= exp_i;
            cnt         <= CNT_LAST;
            acc         <= MONT_ONE;
            op2_q       <= MONT_ONE;
            op_ready_o  <= 1'b0;
            mul_valid_o <= 1'b1;
            state       <= ISSUE_SQR;
          end
        end

        ISSUE_SQR, ISSUE_MUL: begin
          if (mul_ready_i) begin
            mul_valid_o     <= 1'b0;
            mul_res_ready_o <= 1'b1;
            state           <= (state == ISSUE_SQR) ? WAIT_SQR : WAIT_MUL;
          end
        end

        // op2 is preloaded with the next operand so it is already stable when
        // mul_valid_o rises; for a square it is the product arriving now.
        WAIT_SQR, WAIT_MUL: begin
          if (mul_res_valid_i) begin
            acc             <= mul_res_i;
            mul_res_ready_o <= 1'b0;
            if (state == WAIT_SQR && bit_set) begin
              op2_q       <= base_q;
              mul_valid_o <= 1'b1;
              state       <= ISSUE_MUL;
            end else if (cnt == '0) begin
              res_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              cnt         <= cnt - CNT_ONE;
              exp_q       <= exp_q << 1;
              op2_q       <= mul_res_i;
              mul_valid_o <= 1'b1;
              state       <= ISSUE_SQR;
            end
          end
        end

        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            op_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state           <= IDLE;
          op_ready_o      <= 1'b1;
          mul_valid_o     <= 1'b0;
          mul_res_ready_o <= 1'b0;
          res_valid_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule
